axi4lite_cfg_bridge: RTL and testbench
======================================

// Module: axi4lite_cfg_bridge
// PURPOSE
//  AXI4-Lite slave to simple cfg register bus; next generation of the cfg bridge.
//  - AW and W accepted independently; full B/R handshakes with backpressure.
//  - Write strobes forwarded; out-of-range addresses answered with SLVERR.
//  - Configurable read latency of the attached register file.
//  - Sits between the PS general-purpose AXI port and the per-core cfg register files.
// PARAMETERS
//  CFG_DWIDTH  32  data width; 32 or 64
//  CFG_AWIDTH  5   cfg word-address width
//  CFG_NREGS   32  implemented words; index >= CFG_NREGS -> SLVERR; 1..2**CFG_AWIDTH
//  CFG_RD_LAT  1   cycles from cfg_rd_en to valid cfg_rd_data; 1..4
//  AXI_AWIDTH  CFG_AWIDTH+$clog2(CFG_DWIDTH/8)  derived; never overridden
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             async reset, active low
//  cfg_wr_data  out  CFG_DWIDTH    write data
//  cfg_wr_strb  out  CFG_DWIDTH/8  byte enables of the write
//  cfg_wr_addr  out  CFG_AWIDTH    write word index
//  cfg_wr_en    out  1             one-cycle write pulse
//  cfg_rd_data  in   CFG_DWIDTH    read data, valid CFG_RD_LAT cycles after cfg_rd_en
//  cfg_rd_addr  out  CFG_AWIDTH    read word index, held until the R handshake
//  cfg_rd_en    out  1             one-cycle read pulse
//  axi_aw{addr,prot,valid,ready}  AXI_AWIDTH/3/1 in, ready out; prot ignored
//  axi_w{data,strb,valid,ready}   CFG_DWIDTH/CFG_DWIDTH/8/1 in, ready out
//  axi_b{resp,valid}/axi_bready   2/1 out, 1 in
//  axi_ar{addr,prot,valid,ready}  AXI_AWIDTH/3/1 in, ready out; prot ignored
//  axi_r{data,resp,valid}/axi_rready  CFG_DWIDTH/2/1 out, 1 in
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; hold flags cleared; read FSM = IDLE.
//   Deassertion is synchronised externally.
//  Addressing: index = addr[$clog2(CFG_DWIDTH/8) +: CFG_AWIDTH]; low byte bits ignored.
//  Write path:
//   - awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
//   - A handshake captures addr/data/strb into a hold register; AW and W may arrive
//     in either order or in the same cycle.
//   - Cycle after both are held: one-cycle cfg_wr_en pulse and bvalid=1 in the same cycle.
//     cfg_wr_addr/data/strb are registered and stable in that cycle.
//   - Index >= CFG_NREGS: no cfg_wr_en; bresp=2'b10. wstrb==0: no cfg_wr_en; bresp=OKAY.
//   - bvalid holds until bready. Holds clear on the B handshake.
//   - awready/wready rise the cycle after the B handshake; no new AW/W accepted meanwhile.
//  Read path FSM IDLE -> REQ -> WAIT -> RESP -> IDLE:
//   - IDLE: arready=1. AR handshake latches the index -> REQ.
//   - REQ: cfg_rd_en=1 for 1 cycle (0 if out of range) -> WAIT.
//   - WAIT: down-counter from CFG_RD_LAT. At 0, capture cfg_rd_data into the rdata
//     register (or 0 if out of range) -> RESP.
//   - RESP: rvalid=1; rdata/rresp stable until rready. Handshake -> IDLE; arready
//     rises the next cycle.
//   - Index >= CFG_NREGS: rresp=2'b10, otherwise 2'b00.
//   - Minimum AR handshake to rvalid latency = CFG_RD_LAT+2 cycles.
//  Read and write paths are fully independent; simultaneous cfg_wr_en/cfg_rd_en
//   permitted (register file resolves).
//  Reset mid-transaction aborts it silently; no B/R response issued afterwards.
// STRUCTURE
//  Shared header axi4lite_defs.vh: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, read FSM
//   state encodings.
//  One sub-module: axi4lite_cfg_rd (read FSM, latency counter, rdata register).
//   Write path stays inline.
// TESTING
//  1. AW at t0, W at t3 (addr 0x08, data 0xA5A5_0001, strb 0xF) -> cfg_wr_en at t4,
//     addr=2, bresp=0.
//  2. W before AW, bready low 5 cycles -> single cfg_wr_en; bvalid held 5 cycles;
//     awready/wready stay 0.
//  3. Write to index 40 (CFG_NREGS=32) -> no cfg_wr_en, bresp=2'b10.
//     Write with strb=0x0 -> no cfg_wr_en, bresp=0.
//  4. Read with CFG_RD_LAT=3, addr 0x0C -> cfg_rd_addr=3, rvalid 5 cycles after AR;
//     rdata equals cfg_rd_data 3 cycles after cfg_rd_en; rready low 4 cycles,
//     rdata stable.
//  5. Concurrent write idx 1 and read idx 1 -> both complete, responses both OKAY.
//     Read idx 33 -> rdata=0, rresp=2'b10.
//  6. rst_n low during WAIT and with bvalid high -> rvalid/bvalid/cfg_*_en drop
//     immediately. Next AR/AW/W after reset handled normally.

Source files
------------

// File: rtl/axi4lite_cfg_bridge_pkg.sv
// Shared response codes, read FSM encoding and index range helper for the
// AXI4-Lite to cfg register bus bridge.
package axi4lite_cfg_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } rd_state_e;

  function automatic logic idx_out_of_range(input int unsigned idx, input int unsigned nregs);
    return idx >= nregs;
  endfunction

endpackage

// File: rtl/axi4lite_cfg_rd.sv
// Read side of the cfg bridge: AR acceptance, one-cycle cfg read strobe,
// fixed-latency wait and a registered R response held until rready.
module axi4lite_cfg_rd
  import axi4lite_cfg_bridge_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_NREGS  = 32,
  parameter int CFG_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid_i,
  input  logic [CFG_AWIDTH-1:0] ar_idx_i,
  output logic                  ar_ready_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [CFG_DWIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  cfg_rd_en_o,
  output logic [CFG_AWIDTH-1:0] cfg_rd_addr_o,
  input  logic [CFG_DWIDTH-1:0] cfg_rd_data_i
);

  // WAIT spends CFG_RD_LAT-1 extra cycles so capture lands CFG_RD_LAT cycles after the strobe
  localparam logic [2:0] CNT_LOAD = 3'(CFG_RD_LAT - 1);

  rd_state_e             state_q;
  logic                  arready_q;
  logic                  rd_en_q;
  logic [CFG_AWIDTH-1:0] rd_addr_q;
  logic                  oor_q;
  logic [2:0]            cnt_q;
  logic                  rvalid_q;
  logic [CFG_DWIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_oor;

  assign ar_oor = idx_out_of_range(32'(ar_idx_i), CFG_NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      arready_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      oor_q     <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (ar_valid_i && arready_q) begin
            arready_q <= 1'b0;
            rd_addr_q <= ar_idx_i;
            oor_q     <= ar_oor;
            rd_en_q   <= ~ar_oor;
            state_q   <= RD_REQ;
          end
        end
        RD_REQ: begin
          rd_en_q <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q  <= oor_q ? '0 : cfg_rd_data_i;
            rresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RD_RESP: begin
          if (r_ready_i) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign ar_ready_o    = arready_q;
  assign r_valid_o     = rvalid_q;
  assign r_data_o      = rdata_q;
  assign r_resp_o      = rresp_q;
  assign cfg_rd_en_o   = rd_en_q;
  assign cfg_rd_addr_o = rd_addr_q;

endmodule

// File: rtl/axi4lite_cfg_bridge.sv
// AXI4-Lite slave translating single-beat accesses onto a simple cfg register
// bus. Write path is inline; the read path lives in axi4lite_cfg_rd.
module axi4lite_cfg_bridge
  import axi4lite_cfg_bridge_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_NREGS  = 32,
  parameter int CFG_RD_LAT = 1,
  parameter int AXI_AWIDTH = CFG_AWIDTH + $clog2(CFG_DWIDTH / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [CFG_DWIDTH-1:0]   cfg_wr_data,
  output logic [CFG_DWIDTH/8-1:0] cfg_wr_strb,
  output logic [CFG_AWIDTH-1:0]   cfg_wr_addr,
  output logic                    cfg_wr_en,
  input  logic [CFG_DWIDTH-1:0]   cfg_rd_data,
  output logic [CFG_AWIDTH-1:0]   cfg_rd_addr,
  output logic                    cfg_rd_en,
  input  logic [AXI_AWIDTH-1:0]   axi_awaddr,
  input  logic [2:0]              axi_awprot,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [CFG_DWIDTH-1:0]   axi_wdata,
  input  logic [CFG_DWIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [AXI_AWIDTH-1:0]   axi_araddr,
  input  logic [2:0]              axi_arprot,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [CFG_DWIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int BYTE_W = $clog2(CFG_DWIDTH / 8);
  localparam int STRB_W = CFG_DWIDTH / 8;

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  bvalid_q, bvalid_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [CFG_AWIDTH-1:0] aw_idx_q, wr_addr_q, wr_addr_d;
  logic [CFG_DWIDTH-1:0] w_data_q, wr_data_q, wr_data_d;
  logic [STRB_W-1:0]     w_strb_q, wr_strb_q, wr_strb_d;

  logic                  aw_hs, w_hs, b_hs, fire, oor;
  logic [CFG_AWIDTH-1:0] aw_idx_cur;
  logic [CFG_DWIDTH-1:0] w_data_cur;
  logic [STRB_W-1:0]     w_strb_cur;
  logic                  unused_ok;

  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[BYTE_W-1:0], axi_araddr[BYTE_W-1:0]};

  assign aw_hs = axi_awvalid & awready_q;
  assign w_hs  = axi_wvalid & wready_q;
  assign b_hs  = bvalid_q & axi_bready;

  // A beat arriving this cycle is used directly so the write fires one cycle after the later handshake
  assign aw_idx_cur = aw_held_q ? aw_idx_q : axi_awaddr[BYTE_W +: CFG_AWIDTH];
  assign w_data_cur = w_held_q ? w_data_q : axi_wdata;
  assign w_strb_cur = w_held_q ? w_strb_q : axi_wstrb;
  assign fire       = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
  assign oor        = idx_out_of_range(32'(aw_idx_cur), CFG_NREGS);

  always_comb begin
    aw_held_d = b_hs ? 1'b0 : (aw_held_q | aw_hs);
    w_held_d  = b_hs ? 1'b0 : (w_held_q | w_hs);
    bvalid_d  = fire ? 1'b1 : (b_hs ? 1'b0 : bvalid_q);
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
    wr_en_d   = fire & ~oor & (|w_strb_cur);
    bresp_d   = bresp_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    if (fire) begin
      bresp_d   = oor ? RESP_SLVERR : RESP_OKAY;
      wr_addr_d = aw_idx_cur;
      wr_data_d = w_data_cur;
      wr_strb_d = w_strb_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      wr_en_q   <= wr_en_d;
      bresp_q   <= bresp_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  // Hold registers carry payload only; their validity lives in the *_held flags
  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx_q <= axi_awaddr[BYTE_W +: CFG_AWIDTH];
    if (w_hs) begin
      w_data_q <= axi_wdata;
      w_strb_q <= axi_wstrb;
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign cfg_wr_en   = wr_en_q;
  assign cfg_wr_addr = wr_addr_q;
  assign cfg_wr_data = wr_data_q;
  assign cfg_wr_strb = wr_strb_q;

  axi4lite_cfg_rd #(
    .CFG_DWIDTH(CFG_DWIDTH),
    .CFG_AWIDTH(CFG_AWIDTH),
    .CFG_NREGS (CFG_NREGS),
    .CFG_RD_LAT(CFG_RD_LAT)
  ) u_rd (
    .clk          (clk),
    .rst_n        (rst_n),
    .ar_valid_i   (axi_arvalid),
    .ar_idx_i     (axi_araddr[BYTE_W +: CFG_AWIDTH]),
    .ar_ready_o   (axi_arready),
    .r_valid_o    (axi_rvalid),
    .r_ready_i    (axi_rready),
    .r_data_o     (axi_rdata),
    .r_resp_o     (axi_rresp),
    .cfg_rd_en_o  (cfg_rd_en),
    .cfg_rd_addr_o(cfg_rd_addr),
    .cfg_rd_data_i(cfg_rd_data)
  );

endmodule

// File: tb/tb_axi4lite_cfg_bridge.sv
// Directed bench for axi4lite_cfg_bridge with a queue scoreboard and a
// latency-accurate cfg register file model.
module tb_axi4lite_cfg_bridge;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NR  = 32;
  localparam int LAT = 3;
  localparam int AXW = AW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]  cfg_wr_data, cfg_rd_data;
  logic [3:0]     cfg_wr_strb;
  logic [AW-1:0]  cfg_wr_addr, cfg_rd_addr;
  logic           cfg_wr_en, cfg_rd_en;
  logic [AXW-1:0] axi_awaddr = '0, axi_araddr = '0;
  logic [2:0]     axi_awprot = 3'd0, axi_arprot = 3'd0;
  logic           axi_awvalid = 1'b0, axi_awready, axi_wvalid = 1'b0, axi_wready;
  logic [DW-1:0]  axi_wdata = '0, axi_rdata;
  logic [3:0]     axi_wstrb = '0;
  logic [1:0]     axi_bresp, axi_rresp;
  logic           axi_bvalid, axi_bready = 1'b1;
  logic           axi_arvalid = 1'b0, axi_arready, axi_rvalid, axi_rready = 1'b1;

  axi4lite_cfg_bridge #(
    .CFG_DWIDTH(DW), .CFG_AWIDTH(AW), .CFG_NREGS(NR), .CFG_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_strb(cfg_wr_strb), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_data(cfg_rd_data), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_en(cfg_rd_en),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file model: data valid exactly LAT cycles after cfg_rd_en, poison otherwise
  logic [DW-1:0]  mem [64];
  logic [LAT-1:0] vp = '0;
  logic [DW-1:0]  dp [LAT];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
  assign cfg_rd_data = vp[LAT-1] ? dp[LAT-1] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    vp    <= {vp[LAT-2:0], cfg_rd_en};
    dp[0] <= mem[cfg_rd_addr];
    for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    if (cfg_wr_en)
      for (int b = 0; b < DW/8; b++)
        if (cfg_wr_strb[b]) mem[cfg_wr_addr][8*b +: 8] <= cfg_wr_data[8*b +: 8];
  end

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] s;} wr_t;
  typedef struct packed {logic [DW-1:0] d; logic [1:0] r;} rd_t;
  wr_t        wr_q[$];
  logic [1:0] b_q[$];
  rd_t        r_q[$];
  wr_t        we;
  rd_t        re;
  logic [1:0] be;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_rd_en) rd_cnt++;
      if (cfg_wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got cfg_wr_en addr %0h, required no write", cfg_wr_addr);
        end else begin
          we = wr_q.pop_front();
          chk("wr_addr", 64'(cfg_wr_addr), 64'(we.a));
          chk("wr_data", 64'(cfg_wr_data), 64'(we.d));
          chk("wr_strb", 64'(cfg_wr_strb), 64'(we.s));
        end
      end
      if (axi_bvalid && axi_bready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got bresp %0h, required no B response", axi_bresp);
        end else begin
          be = b_q.pop_front();
          chk("bresp", 64'(axi_bresp), 64'(be));
        end
      end
      if (axi_rvalid && axi_rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got rdata %0h, required no R response", axi_rdata);
        end else begin
          re = r_q.pop_front();
          chk("rdata", 64'(axi_rdata), 64'(re.d));
          chk("rresp", 64'(axi_rresp), 64'(re.r));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_aw(input logic [AXW-1:0] a);
    logic hs; int k;
    hs = 1'b0; k = 0;
    axi_awaddr = a; axi_awvalid = 1'b1;
    while (!hs && k < 50) begin
      @(negedge clk); hs = axi_awready; @(posedge clk); #1; k++;
    end
    if (!hs) begin checks++; errors++; $display("FAIL aw_timeout: got no awready, required accept"); end
    axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s);
    logic hs; int k;
    hs = 1'b0; k = 0;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
    while (!hs && k < 50) begin
      @(negedge clk); hs = axi_wready; @(posedge clk); #1; k++;
    end
    if (!hs) begin checks++; errors++; $display("FAIL w_timeout: got no wready, required accept"); end
    axi_wvalid = 1'b0;
  endtask

  task automatic write(input logic [AXW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    logic ah, wh, an, wn; int k;
    ah = 1'b0; wh = 1'b0; k = 0;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    while (!(ah && wh) && k < 50) begin
      @(negedge clk);
      an = axi_awvalid & axi_awready;
      wn = axi_wvalid & axi_wready;
      @(posedge clk); #1;
      if (an) begin ah = 1'b1; axi_awvalid = 1'b0; end
      if (wn) begin wh = 1'b1; axi_wvalid = 1'b0; end
      k++;
    end
    if (!(ah && wh)) begin
      checks++; errors++;
      $display("FAIL write_timeout: got aw %0b w %0b, required both accepted", ah, wh);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    end
  endtask

  task automatic send_ar(input logic [AXW-1:0] a, output int hc);
    logic hs; int k;
    hs = 1'b0; k = 0; hc = 0;
    axi_araddr = a; axi_arvalid = 1'b1;
    while (!hs && k < 50) begin
      @(negedge clk); hs = axi_arready; hc = cyc; @(posedge clk); #1; k++;
    end
    if (!hs) begin checks++; errors++; $display("FAIL ar_timeout: got no arready, required accept"); end
    axi_arvalid = 1'b0;
  endtask

  int hc, hc2, rc, snap;
  logic rv;

  initial begin
    // reset state
    tick(3);
    chk("rst_awready", 64'(axi_awready), 0);
    chk("rst_wready", 64'(axi_wready), 0);
    chk("rst_arready", 64'(axi_arready), 0);
    chk("rst_bvalid", 64'(axi_bvalid), 0);
    chk("rst_rvalid", 64'(axi_rvalid), 0);
    chk("rst_wr_en", 64'(cfg_wr_en), 0);
    chk("rst_rd_en", 64'(cfg_rd_en), 0);
    chk("rst_wr_addr", 64'(cfg_wr_addr), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_arready", 64'(axi_arready), 1);
    chk("idle_awready", 64'(axi_awready), 1);

    // 1: AW at t0, W at t3
    wr_q.push_back('{a: 6'd2, d: 32'hA5A5_0001, s: 4'hF});
    b_q.push_back(2'b00);
    send_aw(8'h08);
    @(negedge clk); chk("t1_awready_held", 64'(axi_awready), 0);
    tick(2);
    send_w(32'hA5A5_0001, 4'hF);
    @(negedge clk);
    chk("t1_wr_en_t4", 64'(cfg_wr_en), 1);
    chk("t1_bvalid_t4", 64'(axi_bvalid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_awready_rise", 64'(axi_awready), 1);
    chk("t1_wready_rise", 64'(axi_wready), 1);
    tick(1);

    // 2: W before AW, bready low for 5 cycles
    snap = wr_cnt;
    axi_bready = 1'b0;
    wr_q.push_back('{a: 6'd5, d: 32'hCAFE_0002, s: 4'h3});
    b_q.push_back(2'b00);
    send_w(32'hCAFE_0002, 4'h3);
    tick(1);
    send_aw(8'h14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_bvalid_held", 64'(axi_bvalid), 1);
      chk("t2_awready_low", 64'(axi_awready), 0);
      chk("t2_wready_low", 64'(axi_wready), 0);
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    tick(3);
    chk("t2_single_wr_en", 64'(wr_cnt - snap), 1);

    // 3: out-of-range index and empty strobe
    snap = wr_cnt;
    b_q.push_back(2'b10);
    write(8'hA0, 32'h1234_5678, 4'hF);
    b_q.push_back(2'b00);
    write(8'h10, 32'h0000_5555, 4'h0);
    tick(4);
    chk("t3_no_wr_en", 64'(wr_cnt - snap), 0);

    // 4: read index 3 with rready low for 4 cycles
    axi_rready = 1'b0;
    r_q.push_back('{d: 32'h1000_0003, r: 2'b00});
    send_ar(8'h0C, hc);
    @(negedge clk);
    chk("t4_rd_en", 64'(cfg_rd_en), 1);
    chk("t4_rd_addr", 64'(cfg_rd_addr), 3);
    rv = 1'b0; rc = 0;
    for (int k = 0; k < 20 && !rv; k++) begin
      @(negedge clk);
      if (axi_rvalid) begin rv = 1'b1; rc = cyc; end
    end
    chk("t4_rvalid_seen", 64'(rv), 1);
    chk("t4_latency", 64'(rc - hc), 5);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rdata_stable", 64'(axi_rdata), 64'h1000_0003);
      chk("t4_rvalid_hold", 64'(axi_rvalid), 1);
      chk("t4_rd_addr_hold", 64'(cfg_rd_addr), 3);
      @(posedge clk); #1;
      if (i != 3) @(negedge clk);
    end
    axi_rready = 1'b1;
    tick(2);
    r_q.push_back('{d: 32'h1000_0002, r: 2'b00});
    send_ar(8'h14, hc);
    tick(8);

    // 5: concurrent write and read of index 1, then out-of-range read
    wr_q.push_back('{a: 6'd1, d: 32'h1111_2222, s: 4'hF});
    b_q.push_back(2'b00);
    r_q.push_back('{d: 32'h1000_0001, r: 2'b00});
    fork
      write(8'h04, 32'h1111_2222, 4'hF);
      send_ar(8'h04, hc2);
    join
    tick(10);
    r_q.push_back('{d: 32'h1111_2222, r: 2'b00});
    send_ar(8'h04, hc);
    tick(8);
    snap = rd_cnt;
    r_q.push_back('{d: 32'h0000_0000, r: 2'b10});
    send_ar(8'h84, hc);
    tick(8);
    chk("t5_oor_no_rd_en", 64'(rd_cnt - snap), 0);

    // 6: reset during WAIT with bvalid pending
    axi_bready = 1'b0;
    wr_q.push_back('{a: 6'd6, d: 32'h0000_0066, s: 4'hF});
    write(8'h18, 32'h0000_0066, 4'hF);
    send_ar(8'h08, hc);
    tick(1);
    chk("t6_bvalid_before", 64'(axi_bvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", 64'(axi_bvalid), 0);
    chk("t6_rst_rvalid", 64'(axi_rvalid), 0);
    chk("t6_rst_wr_en", 64'(cfg_wr_en), 0);
    chk("t6_rst_rd_en", 64'(cfg_rd_en), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    axi_bready = 1'b1;
    tick(3);
    wr_q.push_back('{a: 6'd7, d: 32'h0000_0077, s: 4'hF});
    b_q.push_back(2'b00);
    write(8'h1C, 32'h0000_0077, 4'hF);
    tick(4);
    r_q.push_back('{d: 32'h0000_0077, r: 2'b00});
    send_ar(8'h1C, hc);
    tick(8);

    chk("end_wr_q_empty", 64'(wr_q.size()), 0);
    chk("end_b_q_empty", 64'(b_q.size()), 0);
    chk("end_r_q_empty", 64'(r_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
